alu_cmd_sequencer: RTL and testbench

Command-driven front end for the team's 4-bit flag ALU (op encoding 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL, 111 SHR). It accepts operation commands over a valid/ready channel and reads operands from a 4-entry x 4-bit register file. It drives the combinational ALU from registered outputs, writes the result back, and returns the result and flags over a valid/ready response channel. It also keeps sticky carry/overflow flags for software polling.

---
 rtl/alu_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command front end for the 4-bit flag ALU. It accepts load and ALU commands
// on a valid/ready channel. Operands come from a 4 x 4-bit register file and
// are presented to the external combinational ALU from registers. The result
// is written back to the register file and returned with its flags on a
// valid/ready response channel. Sticky carry/overflow flags are kept for
// software polling.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_load, cmd_op, cmd_ra/rb/rd, cmd_use_imm, cmd_imm   command fields
//   alu_a, alu_b, alu_op          registered ALU operands and opcode
//   alu_result, alu_carry/zero/overflow   ALU outputs
//   rsp_valid / rsp_ready         response handshake
//   rsp_result, rsp_carry/zero/overflow   response payload
//   sticky_carry/overflow, flag_clear     accumulated flags and their clear
//   dbg_sel / dbg_data            combinational register-file read port
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// ISSUE | ALU operands stable, result captured on the closing edge
// RESP  | rsp_valid high, response held until rsp_ready
module alu_cmd_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [1:0] cmd_rd,
    input  logic       cmd_use_imm,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_overflow,
    output logic       sticky_carry,
    output logic       sticky_overflow,
    input  logic       flag_clear,
    input  logic [1:0] dbg_sel,
    output logic [3:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] regs_q [4];
    logic [3:0] regs_d [4];
    logic [1:0] rd_q, rd_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_overflow_q, rsp_overflow_d;
    logic       sticky_carry_q, sticky_carry_d;
    logic       sticky_overflow_q, sticky_overflow_d;

    always_comb begin
        state_d        = state_q;
        regs_d         = regs_q;
        rd_d           = rd_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rsp_result_d   = rsp_result_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        // Clear first; a capture on the same edge then ORs in the new flags,
        // so the sticky state ends up holding only that command's flags.
        sticky_carry_d    = flag_clear ? 1'b0 : sticky_carry_q;
        sticky_overflow_d = flag_clear ? 1'b0 : sticky_overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rd_d = cmd_rd;
                    if (cmd_load) begin
                        regs_d[cmd_rd] = cmd_imm;
                        rsp_result_d   = cmd_imm;
                        rsp_carry_d    = 1'b0;
                        rsp_zero_d     = 1'b0;
                        rsp_overflow_d = 1'b0;
                        state_d        = ST_RESP;
                    end else begin
                        alu_a_d  = regs_q[cmd_ra];
                        alu_b_d  = cmd_use_imm ? cmd_imm : regs_q[cmd_rb];
                        alu_op_d = cmd_op;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                regs_d[rd_q]      = alu_result;
                rsp_result_d      = alu_result;
                rsp_carry_d       = alu_carry;
                rsp_zero_d        = alu_zero;
                rsp_overflow_d    = alu_overflow;
                sticky_carry_d    = sticky_carry_d | alu_carry;
                sticky_overflow_d = sticky_overflow_d | alu_overflow;
                state_d           = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 4'd0;
            end
            rd_q              <= 2'd0;
            alu_a_q           <= 4'd0;
            alu_b_q           <= 4'd0;
            alu_op_q          <= 3'd0;
            rsp_result_q      <= 4'd0;
            rsp_carry_q       <= 1'b0;
            rsp_zero_q        <= 1'b0;
            rsp_overflow_q    <= 1'b0;
            sticky_carry_q    <= 1'b0;
            sticky_overflow_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            regs_q            <= regs_d;
            rd_q              <= rd_d;
            alu_a_q           <= alu_a_d;
            alu_b_q           <= alu_b_d;
            alu_op_q          <= alu_op_d;
            rsp_result_q      <= rsp_result_d;
            rsp_carry_q       <= rsp_carry_d;
            rsp_zero_q        <= rsp_zero_d;
            rsp_overflow_q    <= rsp_overflow_d;
            sticky_carry_q    <= sticky_carry_d;
            sticky_overflow_q <= sticky_overflow_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE) && !rst;
    assign rsp_valid       = (state_q == ST_RESP);
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_op          = alu_op_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_carry       = rsp_carry_q;
    assign rsp_zero        = rsp_zero_q;
    assign rsp_overflow    = rsp_overflow_q;
    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_overflow_q;
    assign dbg_data        = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer. It supplies the combinational 4-bit
// flag ALU and keeps a register-file / sticky-flag model of its own.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load, cmd_use_imm;
    logic [2:0] cmd_op;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_carry, alu_zero, alu_overflow;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_zero, rsp_overflow;
    logic       sticky_carry, sticky_overflow, flag_clear;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] regs_m [4];
    logic       st_c, st_o;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow),
        .flag_clear(flag_clear), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU: {carry, zero, overflow, result[3:0]}
    function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, ov;
        s = 5'd0; r = 4'd0; c = 1'b0; ov = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                        ov = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                        ov = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            default: begin r = {1'b0, a[3:1]}; c = a[0]; end
        endcase
        return {c, (r == 4'd0), ov, r};
    endfunction

    always_comb begin
        {alu_carry, alu_zero, alu_overflow, alu_result} = alu_f(alu_op, alu_a, alu_b);
    end

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk4(tag, dbg_data, regs_m[i]);
        end
    endtask

    // Runs one command from IDLE (called at posedge+1). Holds rsp_ready low
    // for 'stall' RESP cycles while offering a junk command that must be ignored.
    task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [1:0] ra,
                           input logic [1:0] rb, input logic [1:0] rd, input logic ui,
                           input logic [3:0] imm, input logic clr, input int stall,
                           output int acc, output logic [3:0] o_res, output logic o_c,
                           output logic o_z, output logic o_ov);
        logic [3:0] a, b;
        logic [6:0] e;
        a = regs_m[ra];
        b = ui ? imm : regs_m[rb];
        e = ld ? {3'b000, imm} : alu_f(op, a, b);
        cmd_load = ld; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
        cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
        rsp_ready = (stall == 0);
        chk1("ready_before_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
        if (!ld) begin
            chk1("issue_no_rsp", rsp_valid, 1'b0);
            chk4("issue_alu_a", alu_a, a);
            chk4("issue_alu_b", alu_b, b);
            chk4("issue_alu_op", {1'b0, alu_op}, {1'b0, op});
            flag_clear = clr;
            @(posedge clk); #1;
            flag_clear = 1'b0;
            st_c = (clr ? 1'b0 : st_c) | e[6];
            st_o = (clr ? 1'b0 : st_o) | e[4];
        end
        regs_m[rd] = e[3:0];
        chk1("rsp_valid", rsp_valid, 1'b1);
        chk4("rsp_result", rsp_result, e[3:0]);
        chk1("rsp_carry", rsp_carry, e[6]);
        chk1("rsp_zero", rsp_zero, e[5]);
        chk1("rsp_overflow", rsp_overflow, e[4]);
        chk1("sticky_carry", sticky_carry, st_c);
        chk1("sticky_overflow", sticky_overflow, st_o);
        dbg_sel = rd; #1;
        chk4("dbg_rd_written", dbg_data, e[3:0]);
        o_res = rsp_result; o_c = rsp_carry; o_z = rsp_zero; o_ov = rsp_overflow;
        if (stall > 0) begin
            cmd_load = 1'b1; cmd_rd = rd ^ 2'd1; cmd_imm = ~e[3:0]; cmd_valid = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                chk1("bp_rsp_valid", rsp_valid, 1'b1);
                chk4("bp_rsp_result", rsp_result, e[3:0]);
                chk1("bp_cmd_ready", cmd_ready, 1'b0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk1("post_hs_rsp_valid", rsp_valid, 1'b0);
        chk1("post_hs_cmd_ready", cmd_ready, 1'b1);
        chk_regs("regfile");
    endtask

    int         acc0, acc1, acc2, acc3, acc4;
    logic [3:0] r;
    logic       c, z, ov;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0;
        cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_rd = 2'd0; cmd_use_imm = 1'b0;
        cmd_imm = 4'd0; rsp_ready = 1'b1; flag_clear = 1'b0; dbg_sel = 2'd0;
        for (int i = 0; i < 4; i++) regs_m[i] = 4'd0;
        st_c = 1'b0; st_o = 1'b0;

        // reset, then reset mid-RESP
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("rel_cmd_ready", cmd_ready, 1'b1);
        chk1("rel_rsp_valid", rsp_valid, 1'b0);
        cmd_load = 1'b1; cmd_rd = 2'd1; cmd_imm = 4'd5; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk1("pre_rst_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("mid_rst_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        chk1("after_rst_cmd_ready", cmd_ready, 1'b1);
        chk1("after_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("after_rst_sticky_c", sticky_carry, 1'b0);
        chk1("after_rst_sticky_o", sticky_overflow, 1'b0);
        chk_regs("after_rst_regs");
        @(posedge clk); #1;

        // loads + ADD 7+9
        run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd7, 1'b0, 0, acc0, r, c, z, ov);
        run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 4'd9, 1'b0, 0, acc0, r, c, z, ov);
        run_cmd(1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 0, acc0, r, c, z, ov);
        chk4("add79_result", r, 4'h0);
        chk1("add79_carry", c, 1'b1);
        chk1("add79_zero", z, 1'b1);
        chk1("add79_sticky_c", sticky_carry, 1'b1);

        // AND immediate, XOR self
        run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'hC, 1'b0, 0, acc0, r, c, z, ov);
        run_cmd(1'b0, 3'd2, 2'd0, 2'd0, 2'd1, 1'b1, 4'hA, 1'b0, 0, acc0, r, c, z, ov);
        chk4("andi_result", r, 4'h8);
        chk1("andi_zero", z, 1'b0);
        run_cmd(1'b0, 3'd4, 2'd0, 2'd0, 2'd3, 1'b0, 4'h0, 1'b0, 0, acc0, r, c, z, ov);
        chk4("xor_self_result", r, 4'h0);
        chk1("xor_self_zero", z, 1'b1);

        // backpressure: OR r1 = r0 | 3, rsp_ready low 5 cycles
        run_cmd(1'b0, 3'd3, 2'd0, 2'd0, 2'd1, 1'b1, 4'h3, 1'b0, 5, acc0, r, c, z, ov);
        chk4("bp_or_result", r, 4'hF);

        // flag_clear outside ISSUE
        flag_clear = 1'b1;
        @(posedge clk); #1;
        flag_clear = 1'b0;
        st_c = 1'b0; st_o = 1'b0;
        chk1("idle_clear_sticky_c", sticky_carry, 1'b0);

        // ADD 8+8, then SHL with clear on its capture edge
        run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h8, 1'b0, 0, acc0, r, c, z, ov);
        run_cmd(1'b0, 3'd0, 2'd0, 2'd0, 2'd1, 1'b1, 4'h8, 1'b0, 0, acc0, r, c, z, ov);
        chk4("add88_result", r, 4'h0);
        chk1("add88_carry", c, 1'b1);
        chk1("add88_overflow", ov, 1'b1);
        chk1("add88_sticky_o", sticky_overflow, 1'b1);
        run_cmd(1'b0, 3'd6, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0, 1'b1, 0, acc0, r, c, z, ov);
        chk4("shl_result", r, 4'h0);
        chk1("shl_clr_sticky_c", sticky_carry, 1'b1);
        chk1("shl_clr_sticky_o", sticky_overflow, 1'b0);

        // back-to-back spacing
        run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd2, 1'b0, 4'd5, 1'b0, 0, acc0, r, c, z, ov);
        run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd3, 1'b0, 4'd6, 1'b0, 0, acc1, r, c, z, ov);
        run_cmd(1'b0, 3'd1, 2'd3, 2'd2, 2'd1, 1'b0, 4'd0, 1'b0, 0, acc2, r, c, z, ov);
        chk4("sub65_result", r, 4'h1);
        chk1("sub65_carry", c, 1'b0);
        run_cmd(1'b0, 3'd2, 2'd2, 2'd3, 2'd0, 1'b0, 4'd0, 1'b0, 0, acc3, r, c, z, ov);
        chk4("and56_result", r, 4'h4);
        run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 4'd2, 1'b0, 0, acc4, r, c, z, ov);
        chkn("spacing_load_load", acc1 - acc0, 2);
        chkn("spacing_load_alu", acc2 - acc1, 2);
        chkn("spacing_alu_alu", acc3 - acc2, 3);
        chkn("spacing_alu_load", acc4 - acc3, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
